// File: rtl/axi_lite_write_master.sv
// AXI4-Lite single-beat write master: one user request in, one AW+W+B transaction out.
// Latency: accept at cycle 0, AW/W valid cycle 1, BREADY cycle 2, done_valid cycle 3 with a zero-wait slave.
// Backpressure: req_ready low while a write is in flight; AW/W held until their READY; BREADY only after both.
module axi_lite_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,

    output logic                      done_valid,
    output logic [1:0]                done_resp,

    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,

    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,

    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,

    output logic [7:0]                err_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [7:0] ERR_MAX     = 8'hFF;

    logic [1:0]            r_state;
    logic                  r_req_ready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_done_valid;
    logic [1:0]            r_done_resp;
    logic [7:0]            r_err_count;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [2:0]            r_awprot;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;

    // req_ready is only ever high in IDLE, but gate on state too so the intent is explicit
    assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_aw_hs   = r_awvalid && AWREADY;
    assign w_w_hs    = r_wvalid && WREADY;
    // A channel counts as done if it finished earlier or is finishing this cycle
    assign w_aw_done = r_aw_done || w_aw_hs;
    assign w_w_done  = r_w_done || w_w_hs;
    // BREADY is low outside WAIT_RESP, so an early BVALID can never complete here
    assign w_b_hs    = BVALID && r_bready;

    // Transaction sequencing and the registered handshake outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_done_valid <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Also raises req_ready on the first edge after reset release
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (w_b_hs) begin
                        r_bready     <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                end
            endcase
        end
    end

    // Payload capture on accept; values are kept after the handshakes, never cleared
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awaddr <= '0;
            r_awprot <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_accept) begin
            r_awaddr <= req_addr;
            r_awprot <= req_prot;
            r_wdata  <= req_data;
            r_wstrb  <= req_strb;
        end
    end

    // Completion response capture and saturating error counter
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_done_resp <= 2'b00;
            r_err_count <= 8'h00;
        end else if (w_b_hs) begin
            r_done_resp <= BRESP;
            if ((BRESP != RESP_OKAY) && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + 8'h01;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign done_valid = r_done_valid;
    assign done_resp  = r_done_resp;
    assign AWVALID    = r_awvalid;
    assign AWADDR     = r_awaddr;
    assign AWPROT     = r_awprot;
    assign WVALID     = r_wvalid;
    assign WDATA      = r_wdata;
    assign WSTRB      = r_wstrb;
    assign BREADY     = r_bready;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Bench for axi_lite_write_master: scoreboard of accepted requests checked against AXI beats and completions.
// Latency: directed cycle traces check the per-cycle valid/ready/done pattern.
// Backpressure: a configurable slave delays AWREADY/WREADY and can raise BVALID early.
module tb_axi_lite_write_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [7:0]  err_count;

    axi_lite_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .req_prot(req_prot),
        .done_valid(done_valid), .done_resp(done_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .err_count(err_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  resp;
    } txn_t;

    txn_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // slave behaviour knobs
    int         aw_delay  = 0;
    int         w_delay   = 0;
    bit         b_early   = 1'b0;
    logic [1:0] cfg_bresp = 2'b00;

    // per-transaction progress seen by the monitor
    bit aw_got    = 1'b0;
    bit w_got     = 1'b0;
    bit b_sent    = 1'b0;
    bit b_hs_flag = 1'b0;

    int cyc        = 0;
    int last_acc   = -1;
    bit burst_mode = 1'b0;
    int exp_err    = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave: READY after a per-channel delay, BVALID after both beats (or early on request)
    initial begin
        int aw_cnt;
        int w_cnt;
        aw_cnt  = 0;
        w_cnt   = 0;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                AWREADY = 1'b0;
                WREADY  = 1'b0;
                BVALID  = 1'b0;
                aw_cnt  = 0;
                w_cnt   = 0;
                continue;
            end
            if (AWVALID) begin
                AWREADY = (aw_cnt == aw_delay);
                aw_cnt++;
            end else begin
                AWREADY = 1'b0;
                aw_cnt  = 0;
            end
            if (WVALID) begin
                WREADY = (w_cnt == w_delay);
                w_cnt++;
            end else begin
                WREADY = 1'b0;
                w_cnt  = 0;
            end
            if (b_hs_flag) begin
                BVALID    = 1'b0;
                b_hs_flag = 1'b0;
            end else if (!BVALID && !b_sent && exp_q.size() > 0 &&
                         (b_early ? (AWVALID || WVALID) : (aw_got && w_got))) begin
                BVALID = 1'b1;
                BRESP  = exp_q[0].resp;
            end
        end
    end

    // Monitor: mid-cycle sampling of all channels against the scoreboard
    initial begin
        txn_t t;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (!ARESETn) begin
                exp_q.delete();
                aw_got    = 1'b0;
                w_got     = 1'b0;
                b_sent    = 1'b0;
                b_hs_flag = 1'b0;
                exp_err   = 0;
                continue;
            end
            if (BREADY) check_eq("bready_gate", aw_got && w_got, 1);
            if (AWVALID && exp_q.size() > 0) begin
                check_eq("awaddr", AWADDR, exp_q[0].addr);
                check_eq("awprot", AWPROT, exp_q[0].prot);
            end
            if (WVALID && exp_q.size() > 0) begin
                check_eq("wdata", WDATA, exp_q[0].data);
                check_eq("wstrb", WSTRB, exp_q[0].strb);
            end
            if (AWVALID && AWREADY) aw_got = 1'b1;
            if (WVALID && WREADY)   w_got  = 1'b1;
            if (BVALID && BREADY) begin
                b_sent    = 1'b1;
                b_hs_flag = 1'b1;
            end
            if (done_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("done_spurious", done_valid, 0);
                end else begin
                    t = exp_q.pop_front();
                    if (t.resp != 2'b00 && exp_err < 255) exp_err++;
                    check_eq("done_resp", done_resp, t.resp);
                    check_eq("err_count", err_count, exp_err);
                    check_eq("awaddr_kept", AWADDR, t.addr);
                    check_eq("wdata_kept", WDATA, t.data);
                end
            end
            if (req_valid && req_ready) begin
                check_eq("one_outstanding", exp_q.size(), 0);
                if (burst_mode && last_acc >= 0) check_eq("accept_gap", cyc - last_acc, 3);
                last_acc = cyc;
                t.addr = req_addr;
                t.data = req_data;
                t.strb = req_strb;
                t.prot = req_prot;
                t.resp = cfg_bresp;
                exp_q.push_back(t);
                aw_got = 1'b0;
                w_got  = 1'b0;
                b_sent = 1'b0;
            end
        end
    end

    task automatic check_reset_outs(string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_awvalid"}, AWVALID, 0);
        check_eq({tag, "_wvalid"}, WVALID, 0);
        check_eq({tag, "_bready"}, BREADY, 0);
        check_eq({tag, "_done_valid"}, done_valid, 0);
        check_eq({tag, "_done_resp"}, done_resp, 0);
        check_eq({tag, "_awaddr"}, AWADDR, 0);
        check_eq({tag, "_awprot"}, AWPROT, 0);
        check_eq({tag, "_wdata"}, WDATA, 0);
        check_eq({tag, "_wstrb"}, WSTRB, 0);
        check_eq({tag, "_err_count"}, err_count, 0);
    endtask

    task automatic drive_req(logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [2:0] p);
        @(posedge ACLK);
        #1;
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
        req_prot  = p;
        req_valid = 1'b1;
    endtask

    // pat holds one nibble {AWVALID,WVALID,BREADY,done_valid} per cycle, cycle 1 most significant
    task automatic run_trace(string tag, int n, logic [31:0] pat);
        for (int c = 1; c <= n; c++) begin
            @(posedge ACLK);
            #1;
            if (c == 1) req_valid = 1'b0;
            check_eq($sformatf("%s_c%0d", tag, c), {AWVALID, WVALID, BREADY, done_valid},
                     pat[(n - c) * 4 +: 4]);
        end
    endtask

    task automatic wait_idle(string tag);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !req_ready) && g < 200) begin
            @(posedge ACLK);
            #1;
            g++;
        end
        check_eq({tag, "_idle"}, req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        req_prot  = '0;

        // reset values, then req_ready one edge after release
        #12;
        check_reset_outs("rst0");
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check_eq("rel0_pre", req_ready, 0);
        @(posedge ACLK);
        #1;
        check_eq("rel0_post", req_ready, 1);

        // zero-wait slave latency
        drive_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000);
        run_trace("lat", 4, 32'h0000_C210);

        // AWREADY three cycles late, WREADY immediate
        wait_idle("t2");
        aw_delay = 3;
        drive_req(32'h0000_1234, 32'hCAFE_F00D, 4'h3, 3'b010);
        run_trace("awdly", 6, 32'h00C8_8821);

        // BVALID raised while AW/W still pending; accepted exactly once
        wait_idle("t3");
        aw_delay  = 2;
        w_delay   = 1;
        b_early   = 1'b1;
        cfg_bresp = 2'b01;
        drive_req(32'hA5A5_0000, 32'h0123_4567, 4'hC, 3'b111);
        run_trace("bearly", 6, 32'h00CC_8210);

        // 256 SLVERR writes with req_valid held high: saturation and back-to-back accept spacing
        wait_idle("t4");
        aw_delay   = 0;
        w_delay    = 0;
        b_early    = 1'b0;
        cfg_bresp  = 2'b10;
        burst_mode = 1'b1;
        last_acc   = -1;
        @(posedge ACLK);
        #1;
        req_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int g;
            req_addr = $urandom;
            req_data = $urandom;
            req_strb = 4'($urandom_range(15, 0));
            req_prot = 3'($urandom_range(7, 0));
            g = 0;
            do begin
                @(negedge ACLK);
                g++;
            end while (!req_ready && g < 50);
            @(posedge ACLK);
            #1;
        end
        req_valid  = 1'b0;
        wait_idle("t4_end");
        burst_mode = 1'b0;
        check_eq("sat_err_count", err_count, 8'd255);
        check_eq("sat_done_resp", done_resp, 2'b10);

        // reset while AWVALID is held: immediate clear, no completion, clean restart
        cfg_bresp = 2'b00;
        aw_delay  = 20;
        drive_req(32'h0000_0BAD, 32'h5555_AAAA, 4'h1, 3'b001);
        @(posedge ACLK);
        #1;
        req_valid = 1'b0;
        check_eq("mid_awvalid", AWVALID, 1);
        @(posedge ACLK);
        #3;
        ARESETn = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        aw_delay = 0;
        @(posedge ACLK);
        #3;
        ARESETn = 1'b1;
        #1;
        check_eq("rel1_pre", req_ready, 0);
        @(posedge ACLK);
        #1;
        check_eq("rel1_post", req_ready, 1);
        repeat (6) @(posedge ACLK);
        #1;
        drive_req(32'h0000_0020, 32'h1111_2222, 4'h6, 3'b100);
        run_trace("post_rst", 4, 32'h0000_C210);
        wait_idle("t5_end");
        check_eq("final_err_count", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_write_master.md
AXI_LITE_WRITE_MASTER -- requirements
Module: axi_lite_write_master

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, AW address width.
REQ-002 Parameter: DATA_WIDTH, 32, W data width; STRB width = DATA_WIDTH/8.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 ACLK  in  1  clock; all logic on rising edge.
REQ-005 ARESETn  in  1  asynchronous reset, active low.
REQ-006 req_valid  in  1  user write request valid.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_addr / req_data / req_strb / req_prot  in  ADDR_WIDTH / DATA_WIDTH / STRB / 3  request payload.
REQ-009 done_valid  out  1  one-cycle completion pulse.
REQ-010 done_resp  out  2  BRESP of the completed write.
REQ-011 AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH, AWPROT out 3  write-address channel.
REQ-012 WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WSTRB out STRB  write-data channel.
REQ-013 BVALID in 1, BREADY out 1, BRESP in 2  write-response channel.
REQ-014 err_count  out  8  saturating count of non-OKAY responses.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_RESP; all outputs registered.
REQ-016 IDLE: req_ready=1; on req_valid&&req_ready, payload latched into AWADDR/AWPROT/WDATA/WSTRB, AWVALID=1 and WVALID=1 next cycle, req_ready=0 next cycle, state->SEND.
REQ-017 SEND: AWVALID SHALL stay 1 and AWADDR/AWPROT stable until AWVALID&&AWREADY, then AWVALID=0 next cycle; W channel identical and independent.
REQ-018 Neither VALID SHALL wait on any READY; AW and W may complete same cycle or in either order.
REQ-019 When both handshakes have completed (including same cycle), state->WAIT_RESP, BREADY=1 next cycle.
REQ-020 BREADY SHALL be 0 outside WAIT_RESP; BVALID during IDLE/SEND SHALL be ignored.
REQ-021 WAIT_RESP: on BVALID&&BREADY, next cycle: BREADY=0, done_valid=1 for exactly one cycle, done_resp=BRESP, req_ready=1, state->IDLE.
REQ-022 done_resp SHALL hold its value until the next completion.
REQ-023 err_count SHALL increment on each B handshake with BRESP!=2'b00, saturating at 255 (no wrap).
REQ-024 Minimum latency: request accept cycle 0, AW/W valid cycle 1, BREADY cycle 2, done_valid cycle 3 (zero-wait slave).
REQ-025 Requests SHALL not be accepted while not IDLE; one outstanding transaction maximum.
REQ-026 AWADDR/WDATA/WSTRB/AWPROT SHALL retain last values after handshake (no zeroing).

Reset
REQ-027 ARESETn low SHALL immediately force: state IDLE, req_ready 0, AWVALID 0, WVALID 0, BREADY 0, done_valid 0, done_resp 0, AWADDR/AWPROT/WDATA/WSTRB 0, err_count 0.
REQ-028 req_ready SHALL rise on the first ACLK edge after ARESETn deasserts.
REQ-029 Reset mid-transaction SHALL abandon it with no done_valid pulse.

Verification
REQ-030 Zero-wait slave, req addr 0x10 data 0xDEADBEEF strb 0xF -> AW/W valid cycle 1, BREADY cycle 2, done_valid cycle 3, done_resp 00.
REQ-031 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable, BREADY only after AW handshake.
REQ-032 BVALID asserted early during SEND -> BREADY stays 0 until both AW and W done; response then accepted once.
REQ-033 BRESP=2'b10 on 256 consecutive writes -> err_count saturates at 255, done_resp=10.
REQ-034 ARESETn pulsed low while AWVALID=1 -> all outputs 0 asynchronously, no done_valid, req_ready=1 one edge after release.
REQ-035 req_valid held high across transaction -> second request accepted only on cycle req_ready=1 after done.
